// File: rtl/uart_pkg.sv
// Shared definitions for the AVR-to-MB UART transmit path: FSM encoding,
// frame constants and the default 9600-baud bit period at 50 MHz.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_START_LVL   = 1'b0;
    localparam logic UART_STOP_LVL    = 1'b1;
    localparam int   CLK_PER_BIT_9600 = 5208;

    // Transmitter control state kept together so a checker can bind to one signal.
    typedef struct packed {
        uart_state_t state;
        logic [2:0]  bit_idx;
    } tx_fsm_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO of 2^DEPTH_LOG2 entries; the head is visible on dout
// combinationally so a pop can capture it on the same edge.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    // A push into a full FIFO is dropped even when a pop shares the edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes strobed in from the AVR side are queued
// in byte_fifo and shifted out LSB first on tx, frames back-to-back when queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_9600,
    parameter int CTR_SIZE    = 16,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          data,
    input  logic                new_data,
    input  logic                block,
    output logic                tx,
    output logic                busy,
    output logic                full,
    output logic [DEPTH_LOG2:0] level,
    output logic                overrun
);

    localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [2:0]          LAST_DATA = 3'(UART_DATA_BITS - 1);

    // Write handshake: new_data is a one-cycle valid with no back-pressure;
    // ready is ~full sampled before the edge. A valid while full is dropped
    // and reported by a one-cycle overrun pulse on the following cycle.

    tx_fsm_t             fsm_q, fsm_d;
    logic [CTR_SIZE-1:0] ctr_q, ctr_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                overrun_q;
    logic                pop;
    logic                bit_end;
    logic                start_frame;
    logic [7:0]          fifo_dout;
    logic                fifo_empty;

    byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (new_data),
        .pop   (pop),
        .din   (data),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (fifo_empty)
    );

    assign bit_end     = (ctr_q == BIT_LAST);
    assign start_frame = ~fifo_empty & ~block;

    always_comb begin
        fsm_d   = fsm_q;
        ctr_d   = ctr_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (fsm_q.state)
            IDLE: begin
                if (start_frame) begin
                    pop         = 1'b1;
                    shift_d     = fifo_dout;
                    tx_d        = UART_START_LVL;
                    ctr_d       = '0;
                    fsm_d.state = START;
                end
            end
            START: begin
                if (bit_end) begin
                    ctr_d         = '0;
                    tx_d          = shift_q[0];
                    shift_d       = shift_q >> 1;
                    fsm_d.bit_idx = '0;
                    fsm_d.state   = DATA;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    ctr_d = '0;
                    if (fsm_q.bit_idx == LAST_DATA) begin
                        tx_d        = UART_STOP_LVL;
                        fsm_d.state = STOP;
                    end else begin
                        tx_d          = shift_q[0];
                        shift_d       = shift_q >> 1;
                        fsm_d.bit_idx = fsm_q.bit_idx + 3'd1;
                    end
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    ctr_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (start_frame) begin
                        pop         = 1'b1;
                        shift_d     = fifo_dout;
                        tx_d        = UART_START_LVL;
                        fsm_d.state = START;
                    end else begin
                        fsm_d.state = IDLE;
                    end
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            default: begin
                fsm_d.state = IDLE;
                tx_d        = UART_STOP_LVL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= '{state: IDLE, bit_idx: 3'd0};
            ctr_q     <= '0;
            shift_q   <= '0;
            tx_q      <= UART_STOP_LVL;
            overrun_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            ctr_q     <= ctr_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            overrun_q <= new_data & full;
        end
    end

    assign tx      = tx_q;
    assign overrun = overrun_q;
    assign busy    = (fsm_q.state != IDLE) | ~fifo_empty;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter for the AVR-to-MB direction of the serial bridge.
- Accepts bytes from the fast AVR-side interface as single-cycle strobes, holds them in a FIFO, and serializes them on the 9600-baud MB line.
- Frame format is 8N1, LSB first.
- The FIFO absorbs bursts so the unthrottled AVR stream no longer drops bytes while a frame is in flight.

Parameters:
- CLK_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600).
- CTR_SIZE, 16, width of the bit-period counter; must hold CLK_PER_BIT-1.
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 bytes (16).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  8  byte to enqueue.
- new_data  in  1  one-cycle write strobe for data.
- block  in  1  when high, no new frame starts; an in-flight frame completes.
- tx  out  1  serial line, idle high.
- busy  out  1  high while state!=IDLE or FIFO not empty.
- full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- level  out  DEPTH_LOG2+1  current FIFO occupancy.
- overrun  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, busy=0, full=0, level=0, overrun=0.
  - FIFO pointers are cleared and contents discarded.
  - FSM goes to IDLE; bit counter and bit index go to 0.
  - A frame interrupted by reset is abandoned; tx returns high immediately, without waiting for a clock edge.
- Write acceptance:
  - A write is accepted iff new_data=1 and the pre-edge level < 2^DEPTH_LOG2.
  - When full, a write is dropped even if a pop occurs on the same edge. overrun pulses high for exactly one cycle and the FIFO is unchanged.
  - Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both operations take effect.
- Outputs: level, full and busy are registered (or derived from registered state). They update on the edge that performs the push or pop.
- FSM states:
  - IDLE: if level>0 and block=0, pop the head into the shift register, set tx<=0, and go to START.
  - START: hold tx=0 for CLK_PER_BIT cycles, then drive shift[0] and go to DATA.
  - DATA: 8 bits, each CLK_PER_BIT cycles, LSB first. After bit 7, drive tx=1 and go to STOP.
  - STOP: hold tx=1 for CLK_PER_BIT cycles. At its end:
    - if level>0 and block=0, pop and go directly to START with no idle gap;
    - else go to IDLE.
- Latency:
  - A byte accepted on edge N into an empty FIFO with FSM in IDLE and block=0 is popped on edge N+1; tx falls after edge N+1.
  - Total frame length is 10*CLK_PER_BIT cycles.
- Bit counter: counts 0..CLK_PER_BIT-1 and wraps to 0 at each bit boundary. It is width CTR_SIZE; no other arithmetic overflow is possible.
- block:
  - Sampled only in IDLE and at the end of STOP.
  - Assertion mid-frame has no effect on the current frame.
  - Deassertion with data pending starts a frame on the next edge.
- tx is driven from a register; it is glitch-free and never combinational from inputs.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, STOP, 2 bits);
  - UART_DATA_BITS=8, UART_START_LVL=0, UART_STOP_LVL=1;
  - the default CLK_PER_BIT_9600=5208.
- One sub-module: byte_fifo, a synchronous FIFO parameterized by DEPTH_LOG2.
  - Interface: push, pop, din, dout, level, full, empty.
  - Same clk and rst_n.
  - dout shows the head combinationally from the RAM read address.
- FSM, counters and shift register live in uart_tx_fifo.

Test Plan (the bench overrides CLK_PER_BIT=16):
- Reset: write 0x5A, assert rst_n=0 during bit 3 -> tx=1 at once; level=0, busy=0, overrun=0; no further frame after release.
- Single byte 0xA5 written at edge N:
  - tx=0 from N+1 for 16 cycles, then 1,0,1,0,0,1,0,1 each for 16 cycles, then stop=1 for 16 cycles;
  - busy falls 160 cycles after tx fell.
- Burst of 18 writes 0x00..0x11 on consecutive cycles:
  - 17 accepted; the 18th is dropped with a single overrun pulse and full=1 at that edge;
  - 17 contiguous frames follow, 170*16 cycles with no idle gap, in order 0x00..0x10.
- block=1, write 0x11,0x22,0x33 -> tx stays 1, level=3, busy=1; deassert block -> tx falls on the next edge and three frames follow back-to-back.
- Assert block during the DATA bits of frame 1 of 2 -> frame 1 completes intact, tx stays idle-high, level=1 until block is released.
- With level=5 and a frame ending, write a byte on the exact pop edge -> level stays 5 and no overrun pulse occurs.
